uart_mem_responder: RTL and testbench
=====================================

Name: uart_mem_responder

Overview:
Far-end memory responder for the bitty UART fetch/load-store link. It receives command frames from the UART receiver and serves reads and writes against a local 256x16 word store. Read data and acknowledgements go back out through the UART transmitter. Used in the board-level companion and benches as the memory that fetch and bitty load/store traffic talks to.

Parameters:
ADDR_W, 8, word address width; store depth = 2**ADDR_W
TIMEOUT_CYCLES, 50000, idle cycles allowed between bytes of one frame (optional feature only)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
rx_done  in  1  one-cycle pulse: rx_data valid
rx_data  in  8  received byte
tx_done  in  1  one-cycle pulse: transmitter finished current byte
tx_en  out  1  one-cycle start pulse to transmitter
tx_data  out  8  byte to send; held stable from tx_en until tx_done
load_en  in  1  backdoor preload strobe
load_addr  in  ADDR_W  preload address
load_data  in  16  preload word
busy  out  1  high in any state other than IDLE
cmd_err  out  1  one-cycle pulse on protocol error

Behaviour:
- Frame format, all fixed by this spec:
  - READ: 0x01, addr. Reply is mem[addr][15:8], then mem[addr][7:0].
  - WRITE: 0x02, addr, hi, lo. Writes {hi,lo}, then replies ACK 0x06.
  - Any other first byte: reply NAK 0x15 and pulse cmd_err.
- Reset values: tx_en=0, tx_data=0x00, busy=0, cmd_err=0, state=IDLE. Store contents are not reset.
- States:
  - IDLE: on rx_done, 0x01 goes to R_ADDR, 0x02 goes to W_ADDR, anything else goes to SEND_NAK.
  - R_ADDR: on rx_done, latch addr and go to R_MEM.
  - R_MEM: one cycle for the synchronous read; go to SEND_HI.
  - SEND_HI: pulse tx_en with the high byte; go to WAIT_HI.
  - WAIT_HI: on tx_done go to SEND_LO.
  - SEND_LO: pulse tx_en with the low byte; go to WAIT_LO.
  - WAIT_LO: on tx_done go to IDLE.
  - W_ADDR: on rx_done, latch addr; go to W_HI.
  - W_HI: on rx_done, latch hi; go to W_LO.
  - W_LO: on rx_done, write mem[addr]={hi,rx_data} in that same cycle; go to SEND_ACK.
  - SEND_ACK, WAIT_ACK: same pattern as SEND_HI/WAIT_HI, then IDLE.
  - SEND_NAK, WAIT_NAK: same pattern, then IDLE.
- Latency:
  - READ: tx_en for the high byte is exactly 2 cycles after the rx_done that carries addr.
  - WRITE: the ACK tx_en is 1 cycle after the rx_done that carries lo.
- tx_en is high for exactly one cycle per byte. No new tx_en is issued before tx_done for the previous byte.
- rx_done during any SEND_*/WAIT_* state: byte dropped, cmd_err pulses, state unchanged.
- tx_done outside WAIT_* states is ignored.
- load_en is honoured only in IDLE, and only when rx_done is low in the same cycle; it writes load_data in that cycle. Otherwise load_en is ignored.
- Addresses use the full ADDR_W range; 0xFF is valid. There is no wrap or bounds error.
- Reset asserted mid-frame: the next cycle is IDLE with tx_en=0. A partially received WRITE never commits.

Optional Feature:
Macro UART_MEM_RESP_TIMEOUT_EN.
- Defined:
  - A counter clears on each rx_done and runs in R_ADDR, W_ADDR, W_HI and W_LO.
  - When it reaches TIMEOUT_CYCLES, pulse cmd_err and return to IDLE without writing.
  - The counter does not run in other states.
- Not defined: the counter is absent and the block waits indefinitely for the next frame byte.

Decomposition:
- Shared package holds:
  - command and reply constants: CMD_READ=0x01, CMD_WRITE=0x02, RSP_ACK=0x06, RSP_NAK=0x15;
  - the state enumeration encoding, 4 bits.
- One natural sub-module: uart_mem_store, a 2**ADDR_W x 16 single-port synchronous RAM with 1-cycle read latency. The responder arbitrates write requests onto its single write port.
- The FSM, byte latches and timeout counter stay in uart_mem_responder.

Test Plan:
- Preload mem[0x10]=0xA5C3 via load_en; send 0x01,0x10 → tx bytes 0xA5 then 0xC3; high-byte tx_en exactly 2 cycles after the addr rx_done; busy drops after the second tx_done.
- Send 0x02,0xFF,0x12,0x34 → reply 0x06. Then send 0x01,0xFF → reply 0x12, 0x34.
- Send 0x7E → reply 0x15, cmd_err pulses once, block returns to IDLE. A following 0x01,0x10 is served normally.
- Inject rx_done=0x55 while in WAIT_HI of a read → cmd_err pulses once. The read reply completes unchanged; 0x55 is not treated as a command.
- Send 0x02,0x20,0xBE, then assert reset for 1 cycle and read 0x20 → old contents returned; tx_en is 0 in the cycle after reset.
- With UART_MEM_RESP_TIMEOUT_EN and TIMEOUT_CYCLES=100, send 0x02,0x30 then nothing for 100 cycles → cmd_err pulses and busy goes to 0. mem[0x30] is unchanged, and no tx_en is issued.

Source files
------------

// File: rtl/uart_mem_responder_pkg.sv
// Shared definitions for the UART memory responder: command/reply byte
// values and the responder state encoding.
package uart_mem_responder_pkg;

  localparam logic [7:0] CMD_READ  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_R_ADDR   = 4'd1,
    ST_R_MEM    = 4'd2,
    ST_SEND_HI  = 4'd3,
    ST_WAIT_HI  = 4'd4,
    ST_SEND_LO  = 4'd5,
    ST_WAIT_LO  = 4'd6,
    ST_W_ADDR   = 4'd7,
    ST_W_HI     = 4'd8,
    ST_W_LO     = 4'd9,
    ST_SEND_ACK = 4'd10,
    ST_WAIT_ACK = 4'd11,
    ST_SEND_NAK = 4'd12,
    ST_WAIT_NAK = 4'd13
  } state_e;

  // States that start a transmitter byte (tx_en is high in exactly these).
  function automatic logic is_send(input state_e s);
    return (s == ST_SEND_HI) || (s == ST_SEND_LO) ||
           (s == ST_SEND_ACK) || (s == ST_SEND_NAK);
  endfunction

  // States owned by the reply path; an incoming byte here is a protocol error.
  function automatic logic is_reply(input state_e s);
    return is_send(s) || (s == ST_WAIT_HI) || (s == ST_WAIT_LO) ||
           (s == ST_WAIT_ACK) || (s == ST_WAIT_NAK);
  endfunction

endpackage

// File: rtl/uart_mem_store.sv
// Single-port 2**ADDR_W x 16 synchronous RAM, one-cycle read latency.
// rdata only changes on a read, so it holds while a reply is being sent.
module uart_mem_store #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  logic [15:0] mem [2**ADDR_W];

  // Write has priority over read on the shared address port.
  // NOTE: the array has no reset; contents survive reset and map onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/uart_mem_responder.sv
// Far-end memory responder for the bitty UART fetch/load-store link.
// Serves READ (0x01,addr) and WRITE (0x02,addr,hi,lo) frames against a local
// word store; replies go out one byte at a time through the transmitter.
// Optional build macro UART_MEM_RESP_TIMEOUT_EN adds an inter-byte timeout
// that abandons a partially received frame after TIMEOUT_CYCLES idle cycles.
module uart_mem_responder
  import uart_mem_responder_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_done,
  input  logic [7:0]        rx_data,
  input  logic              tx_done,
  output logic              tx_en,
  output logic [7:0]        tx_data,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [15:0]       load_data,
  output logic              busy,
  output logic              cmd_err
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        hi_q, hi_d;
  logic              cmd_err_d;

  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata, mem_rdata;

`ifdef UART_MEM_RESP_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt_q;
  logic             frame_wait;
  logic             timeout_hit;

  assign frame_wait  = (state_q == ST_R_ADDR) || (state_q == ST_W_ADDR) ||
                       (state_q == ST_W_HI)   || (state_q == ST_W_LO);
  assign timeout_hit = frame_wait && !rx_done &&
                       (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Idle-cycle counter between bytes of a frame; parked at zero elsewhere.
  always_ff @(posedge clk) begin
    if (!reset || rx_done || !frame_wait) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end
`endif

  // Word store; the FSM below arbitrates its single port.
  uart_mem_store #(.ADDR_W(ADDR_W)) u_store (
    .clk   (clk),
    .we    (mem_we & reset),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // State, latched address/high byte and the registered error pulse.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      hi_q    <= '0;
      cmd_err <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      hi_q    <= hi_d;
      cmd_err <= cmd_err_d;
    end
  end

  // Next-state, byte latching and store port arbitration.
  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    hi_d      = hi_q;
    cmd_err_d = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = {hi_q, rx_data};

    case (state_q)
      ST_IDLE: begin
        if (rx_done) begin
          if (rx_data == CMD_READ) begin
            state_d = ST_R_ADDR;
          end else if (rx_data == CMD_WRITE) begin
            state_d = ST_W_ADDR;
          end else begin
            state_d   = ST_SEND_NAK;
            cmd_err_d = 1'b1;
          end
        end else if (load_en) begin
          mem_we    = 1'b1;
          mem_addr  = load_addr;
          mem_wdata = load_data;
        end
      end
      ST_R_ADDR: if (rx_done) begin
        addr_d  = ADDR_W'(rx_data);
        state_d = ST_R_MEM;
      end
      ST_R_MEM: begin
        mem_re  = 1'b1;
        state_d = ST_SEND_HI;
      end
      ST_SEND_HI:  state_d = ST_WAIT_HI;
      ST_WAIT_HI:  if (tx_done) state_d = ST_SEND_LO;
      ST_SEND_LO:  state_d = ST_WAIT_LO;
      ST_WAIT_LO:  if (tx_done) state_d = ST_IDLE;
      ST_W_ADDR: if (rx_done) begin
        addr_d  = ADDR_W'(rx_data);
        state_d = ST_W_HI;
      end
      ST_W_HI: if (rx_done) begin
        hi_d    = rx_data;
        state_d = ST_W_LO;
      end
      ST_W_LO: if (rx_done) begin
        mem_we  = 1'b1;
        state_d = ST_SEND_ACK;
      end
      ST_SEND_ACK: state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: if (tx_done) state_d = ST_IDLE;
      ST_SEND_NAK: state_d = ST_WAIT_NAK;
      ST_WAIT_NAK: if (tx_done) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    // A byte arriving while a reply is in flight is dropped and flagged.
    if (is_reply(state_q) && rx_done) begin
      cmd_err_d = 1'b1;
    end

`ifdef UART_MEM_RESP_TIMEOUT_EN
    if (timeout_hit) begin
      state_d   = ST_IDLE;
      cmd_err_d = 1'b1;
    end
`endif
  end

  // Transmit byte selection; held through the WAIT state until tx_done.
  always_comb begin
    tx_data = 8'h00;
    case (state_q)
      ST_SEND_HI, ST_WAIT_HI:   tx_data = mem_rdata[15:8];
      ST_SEND_LO, ST_WAIT_LO:   tx_data = mem_rdata[7:0];
      ST_SEND_ACK, ST_WAIT_ACK: tx_data = RSP_ACK;
      ST_SEND_NAK, ST_WAIT_NAK: tx_data = RSP_NAK;
      default:                  tx_data = 8'h00;
    endcase
  end

  assign tx_en = is_send(state_q);
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_mem_responder.sv
// Self-checking bench for uart_mem_responder: randomized READ/WRITE/bad-command
// traffic against a word-array model, plus directed boundary cases.
module tb_uart_mem_responder;

  localparam logic [7:0] CMD_READ  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;
`ifdef UART_MEM_RESP_TIMEOUT_EN
  localparam int TO_CYCLES = 100;
`else
  localparam int TO_CYCLES = 50000;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_done = 1'b0;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        load_en = 1'b0;
  logic [7:0]  load_addr = 8'h00;
  logic [15:0] load_data = 16'h0000;
  logic        busy;
  logic        cmd_err;

  logic [15:0] model [256];
  int          n_vec  = 0;
  int          n_miss = 0;
  int          err_pulses = 0;

  uart_mem_responder #(.ADDR_W(8), .TIMEOUT_CYCLES(TO_CYCLES)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_done   (rx_done),
    .rx_data   (rx_data),
    .tx_done   (tx_done),
    .tx_en     (tx_en),
    .tx_data   (tx_data),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .busy      (busy),
    .cmd_err   (cmd_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (reset && cmd_err) err_pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  // Acts as the transmitter for one byte: waits for tx_en (bounded), checks
  // the byte and its latency, holds for a random time, then returns tx_done.
  task automatic recv_byte(input string tag, input logic [7:0] exp,
                           input int exp_lat, input bit inject);
    int n = 1;
    int gap;
    logic [7:0] got;
    bit held_ok = 1'b1;
    while (!tx_en && n < 200) begin
      tick();
      n++;
    end
    if (!tx_en) begin
      check({tag, "_tx_en_timeout"}, 32'd0, 32'd1);
      return;
    end
    got = tx_data;
    check({tag, "_data"}, got, exp);
    if (exp_lat > 0) check({tag, "_lat"}, n, exp_lat);
    gap = $urandom_range(1, 4);
    for (int i = 0; i < gap; i++) begin
      tick();
      if (inject && i == 0) begin
        rx_data = 8'h55;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
      end
      if (tx_en || tx_data !== got) held_ok = 1'b0;
    end
    check({tag, "_held"}, held_ok, 1'b1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, input bit inject);
    send_byte(CMD_READ);
    idle($urandom_range(0, 3));
    send_byte(a);
    recv_byte("rd_hi", model[a][15:8], 2, inject);
    recv_byte("rd_lo", model[a][7:0], 0, 1'b0);
    check("rd_busy_done", busy, 1'b0);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [15:0] d);
    send_byte(CMD_WRITE);
    idle($urandom_range(0, 3));
    send_byte(a);
    idle($urandom_range(0, 3));
    send_byte(d[15:8]);
    idle($urandom_range(0, 3));
    send_byte(d[7:0]);
    model[a] = d;
    recv_byte("wr_ack", RSP_ACK, 1, 1'b0);
    check("wr_busy_done", busy, 1'b0);
  endtask

  task automatic do_bad(input logic [7:0] b);
    int e0 = err_pulses;
    send_byte(b);
    recv_byte("nak", RSP_NAK, 1, 1'b0);
    check("nak_busy_done", busy, 1'b0);
    check("nak_err_pulses", err_pulses - e0, 1);
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] b;
    int e0;
    int op;

    idle(3);
    check("rst_tx_en", tx_en, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_cmd_err", cmd_err, 1'b0);
    reset = 1'b1;
    tick();

    // Backdoor preload of the whole store.
    for (int i = 0; i < 256; i++) begin
      load_en = 1'b1;
      load_addr = 8'(i);
      load_data = 16'($urandom);
      model[i] = load_data;
      tick();
    end
    load_en = 1'b1;
    load_addr = 8'h10;
    load_data = 16'hA5C3;
    model[8'h10] = 16'hA5C3;
    tick();
    load_en = 1'b0;

    // Directed: preloaded read, top-address write/read, bad command.
    do_read(8'h10, 1'b0);
    do_write(8'hFF, 16'h1234);
    do_read(8'hFF, 1'b0);
    do_bad(8'h7E);
    do_read(8'h10, 1'b0);

    // Byte injected during WAIT_HI is dropped and flagged.
    e0 = err_pulses;
    do_read(8'h10, 1'b1);
    check("inject_err_pulses", err_pulses - e0, 1);
    idle(3);
    check("inject_no_tx", tx_en, 1'b0);
    check("inject_idle", busy, 1'b0);

    // load_en with rx_done in IDLE is ignored.
    a = 8'h33;
    rx_data = CMD_READ;
    rx_done = 1'b1;
    load_en = 1'b1;
    load_addr = a;
    load_data = ~model[a];
    tick();
    rx_done = 1'b0;
    load_en = 1'b0;
    send_byte(a);
    recv_byte("ld_rx_hi", model[a][15:8], 2, 1'b0);
    recv_byte("ld_rx_lo", model[a][7:0], 0, 1'b0);

    // load_en outside IDLE is ignored.
    send_byte(CMD_WRITE);
    load_en = 1'b1;
    load_addr = 8'h40;
    load_data = ~model[8'h40];
    tick();
    load_en = 1'b0;
    send_byte(8'h41);
    send_byte(8'h11);
    send_byte(8'h22);
    model[8'h41] = 16'h1122;
    recv_byte("ld_busy_ack", RSP_ACK, 1, 1'b0);
    do_read(8'h40, 1'b0);
    do_read(8'h41, 1'b0);

    // Reset in the middle of a WRITE: nothing commits.
    send_byte(CMD_WRITE);
    send_byte(8'h20);
    send_byte(8'hBE);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("midrst_tx_en", tx_en, 1'b0);
    check("midrst_busy", busy, 1'b0);
    tick();
    do_read(8'h20, 1'b0);

`ifdef UART_MEM_RESP_TIMEOUT_EN
    // Abandoned WRITE times out without writing or replying.
    begin
      int tx_seen = 0;
      bool_busy_mid: begin end
      e0 = err_pulses;
      send_byte(CMD_WRITE);
      send_byte(8'h30);
      for (int i = 0; i < 90; i++) begin
        if (tx_en) tx_seen++;
        tick();
      end
      check("to_busy_before", busy, 1'b1);
      for (int i = 0; i < 20; i++) begin
        if (tx_en) tx_seen++;
        tick();
      end
      check("to_err_pulses", err_pulses - e0, 1);
      check("to_busy_after", busy, 1'b0);
      check("to_no_tx", tx_seen, 0);
      do_read(8'h30, 1'b0);
    end
`endif

    // Randomized traffic.
    for (int k = 0; k < 60; k++) begin
      op = $urandom_range(0, 9);
      a = 8'($urandom);
      if (op < 5) begin
        do_read(a, 1'b0);
      end else if (op < 9) begin
        do_write(a, 16'($urandom));
      end else begin
        b = 8'($urandom);
        while (b == CMD_READ || b == CMD_WRITE) b = 8'($urandom);
        do_bad(b);
      end
      idle($urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
